wb_stage: RTL



---
 rtl/wb_stage.sv | 207 ++++++++++++++++++++
 1 files changed

// File: rtl/wb_stage.sv
// Write-back stage: commits RF/CSR writes, raises exception/ertn flush pulses, drives trace and forwarding.
// Optional performance counters are enabled by defining WB_PERF_CNT_EN.
module wb_stage #(
  parameter int          BUS_W  = 188,
  parameter logic [31:0] RST_PC = 32'h1c000000
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             MEM_to_WB_valid,
  output logic             WB_allow_in,
  input  logic [BUS_W-1:0] MEM_to_WB_bus,
  output logic             rf_we,
  output logic [4:0]       rf_waddr,
  output logic [31:0]      rf_wdata,
  output logic [37:0]      WB_wr_bus,
  output logic             csr_we,
  output logic [13:0]      csr_num,
  output logic [31:0]      csr_wmask,
  output logic [31:0]      csr_wvalue,
  output logic             wb_ex,
  output logic [5:0]       wb_ecode,
  output logic [31:0]      wb_pc,
  output logic [31:0]      wb_vaddr,
  output logic             ertn_flush,
  output logic [31:0]      debug_wb_pc,
  output logic [3:0]       debug_wb_rf_we,
  output logic [4:0]       debug_wb_rf_wnum,
  output logic [31:0]      debug_wb_rf_wdata
`ifdef WB_PERF_CNT_EN
  ,
  output logic [31:0]      perf_commit_cnt,
  output logic [31:0]      perf_ex_cnt
`endif
);

  localparam logic [0:0] S_RUN   = 1'b0;
  localparam logic [0:0] S_FLUSH = 1'b1;

  localparam logic [5:0] EC_ADEF = 6'h08;
  localparam logic [5:0] EC_SYS  = 6'h0B;
  localparam logic [5:0] EC_ALE  = 6'h09;
  localparam logic [5:0] EC_BRK  = 6'h0C;
  localparam logic [5:0] EC_INE  = 6'h0D;
  localparam logic [5:0] EC_INT  = 6'h00;

  // Bus layout is fixed at 188 bits; the instruction word itself is not needed here.
  logic        w_bus_csr_we;
  logic [13:0] w_bus_csr_num;
  logic [31:0] w_bus_csr_wmask;
  logic [31:0] w_bus_csr_wvalue;
  logic        w_bus_inst_ertn;
  logic [5:0]  w_bus_ex_type;
  logic [31:0] w_bus_result;
  logic        w_bus_gr_we;
  logic [4:0]  w_bus_dest;
  logic [31:0] w_bus_pc;
  logic [31:0] w_unused_inst;

  assign w_bus_csr_we     = MEM_to_WB_bus[187];
  assign w_bus_csr_num    = MEM_to_WB_bus[186:173];
  assign w_bus_csr_wmask  = MEM_to_WB_bus[172:141];
  assign w_bus_csr_wvalue = MEM_to_WB_bus[140:109];
  assign w_bus_inst_ertn  = MEM_to_WB_bus[108];
  assign w_bus_ex_type    = MEM_to_WB_bus[107:102];
  assign w_bus_result     = MEM_to_WB_bus[101:70];
  assign w_bus_gr_we      = MEM_to_WB_bus[69];
  assign w_bus_dest       = MEM_to_WB_bus[68:64];
  assign w_bus_pc         = MEM_to_WB_bus[63:32];
  assign w_unused_inst    = MEM_to_WB_bus[31:0];

  logic [0:0]  r_state;
  logic        r_valid;
  logic        r_csr_we;
  logic [13:0] r_csr_num;
  logic [31:0] r_csr_wmask;
  logic [31:0] r_csr_wvalue;
  logic        r_inst_ertn;
  logic [5:0]  r_ex_type;
  logic [31:0] r_result;
  logic        r_gr_we;
  logic [4:0]  r_dest;
  logic [31:0] r_pc;

  logic        w_ex;
  logic        w_ertn;
  logic        w_rf_we;
  logic        w_load;
  logic [5:0]  w_ecode;
  logic [31:0] w_vaddr;

  assign WB_allow_in = (r_state == S_RUN);
  assign w_load      = MEM_to_WB_valid & WB_allow_in;
  assign w_ex        = r_valid & (|r_ex_type);
  assign w_ertn      = r_valid & r_inst_ertn & ~(|r_ex_type);
  assign w_rf_we     = r_valid & r_gr_we & ~w_ex;

  // Highest-priority cause wins: INT > ADEF > INE > SYS > BRK > ALE.
  always_comb begin
    w_ecode = EC_INT;
    w_vaddr = 32'h0;
    if (r_ex_type[5]) begin
      w_ecode = EC_INT;
    end else if (r_ex_type[0]) begin
      w_ecode = EC_ADEF;
      w_vaddr = r_pc;
    end else if (r_ex_type[4]) begin
      w_ecode = EC_INE;
    end else if (r_ex_type[1]) begin
      w_ecode = EC_SYS;
    end else if (r_ex_type[3]) begin
      w_ecode = EC_BRK;
    end else if (r_ex_type[2]) begin
      w_ecode = EC_ALE;
      w_vaddr = r_result;
    end
  end

  // One dead cycle after any flush so nothing younger commits behind it.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_state <= S_RUN;
    end else begin
      case (r_state)
        S_RUN:   if (w_ex | w_ertn) r_state <= S_FLUSH;
        S_FLUSH: r_state <= S_RUN;
        default: r_state <= S_RUN;
      endcase
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_valid <= 1'b0;
    end else if (WB_allow_in) begin
      r_valid <= MEM_to_WB_valid;
    end else begin
      r_valid <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_csr_we     <= 1'b0;
      r_csr_num    <= 14'h0;
      r_csr_wmask  <= 32'h0;
      r_csr_wvalue <= 32'h0;
      r_inst_ertn  <= 1'b0;
      r_ex_type    <= 6'h0;
      r_result     <= 32'h0;
      r_gr_we      <= 1'b0;
      r_dest       <= 5'h0;
      r_pc         <= RST_PC;
    end else if (w_load) begin
      r_csr_we     <= w_bus_csr_we;
      r_csr_num    <= w_bus_csr_num;
      r_csr_wmask  <= w_bus_csr_wmask;
      r_csr_wvalue <= w_bus_csr_wvalue;
      r_inst_ertn  <= w_bus_inst_ertn;
      r_ex_type    <= w_bus_ex_type;
      r_result     <= w_bus_result;
      r_gr_we      <= w_bus_gr_we;
      r_dest       <= w_bus_dest;
      r_pc         <= w_bus_pc;
    end
  end

  assign rf_we      = w_rf_we;
  assign rf_waddr   = r_dest;
  assign rf_wdata   = r_result;
  assign WB_wr_bus  = {w_rf_we, r_dest, r_result};

  assign csr_we     = r_valid & r_csr_we & ~w_ex;
  assign csr_num    = r_csr_num;
  assign csr_wmask  = r_csr_wmask;
  assign csr_wvalue = r_csr_wvalue;

  assign wb_ex      = w_ex;
  assign wb_ecode   = w_ecode;
  assign wb_pc      = r_pc;
  assign wb_vaddr   = w_vaddr;
  assign ertn_flush = w_ertn;

  assign debug_wb_pc       = r_pc;
  assign debug_wb_rf_we    = {4{w_rf_we}};
  assign debug_wb_rf_wnum  = r_dest;
  assign debug_wb_rf_wdata = r_result;

`ifdef WB_PERF_CNT_EN
  logic [31:0] r_perf_commit_cnt;
  logic [31:0] r_perf_ex_cnt;

  // Both counters wrap naturally at 32 bits.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_perf_commit_cnt <= 32'h0;
      r_perf_ex_cnt     <= 32'h0;
    end else begin
      if (r_valid & ~w_ex) r_perf_commit_cnt <= r_perf_commit_cnt + 32'd1;
      if (w_ex)            r_perf_ex_cnt     <= r_perf_ex_cnt + 32'd1;
    end
  end

  assign perf_commit_cnt = r_perf_commit_cnt;
  assign perf_ex_cnt     = r_perf_ex_cnt;
`endif

endmodule
